mem_stage: RTL and testbench

Pipeline memory-access stage that consumes the execute stage's result, store data and branch outcome, and performs loads and stores over a request/acknowledge data-memory port. It produces the writeback bundle and the registered branch redirect. It also drives `stall_flag` back to the execute stage, holding it frozen while a memory access is outstanding.

---
 rtl/mem_stage_if.sv | 35 +++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Request/acknowledge data-memory bus between the memory-access stage and the
// data memory.
//
//   req    stage -> memory  access request, held until ack
//   we     stage -> memory  request is a write
//   addr   stage -> memory  word-aligned byte address
//   wdata  stage -> memory  store data
//   ack    memory -> stage  one-cycle completion pulse
//   rdata  memory -> stage  read data, valid with ack
//
// master: the pipeline stage side.  slave: the memory side.
// -----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory-access stage.  Takes the execute bundle, performs at most one
// outstanding load/store over the dmem bus, and produces the writeback bundle
// and the registered branch redirect.  stall_flag freezes the execute stage
// while an access is in flight.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ex_*                  execute bundle (ex_result doubles as byte address)
//   stall_flag            combinational stall back to execute
//   dmem (master)         request/ack data-memory bus
//   wb_valid/reg_write/rd/data   writeback bundle (wb_valid is a pulse)
//   pc_src, pc_target     branch redirect (pc_src is a pulse)
//   mem_err               pulse on malformed or misaligned memory op
//
// The address is taken from the low ADDR_W bits of ex_result, so ADDR_W must
// not exceed DATA_W.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              stall_flag,
    mem_stage_if.master       dmem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_src,
    output logic [ADDR_W-1:0] pc_target,
    output logic              mem_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, next_state;

    logic       accept;
    logic       one_op;
    logic       aligned;
    logic       launch;
    logic       bad_op;
    logic       alu_op;
    logic       done;

    // Access context kept across the WAIT state
    logic [4:0] lat_rd;
    logic       lat_reg_write;
    logic       lat_load;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Instruction classification, next state and the combinational stall.
    // Only IDLE looks at the execute bundle; in WAIT it is ignored entirely.
    always_comb begin
        next_state = state;
        accept     = (state == S_IDLE) && ex_valid;
        one_op     = ex_mem_read ^ ex_mem_write;
        aligned    = (ex_result[1:0] == 2'b00);
        launch     = accept && one_op && aligned;
        bad_op     = accept && ((ex_mem_read && ex_mem_write) || (one_op && !aligned));
        alu_op     = accept && !ex_mem_read && !ex_mem_write;
        done       = (state == S_WAIT) && dmem.ack;
        case (state)
            S_IDLE: if (launch) next_state = S_WAIT;
            S_WAIT: if (dmem.ack) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // Low in the ack cycle so execute advances on the completing edge
        stall_flag = launch || ((state == S_WAIT) && !dmem.ack);
    end

    // Registered outputs: memory request, writeback bundle, redirect, error.
    // Pulses default low each cycle; data outputs hold until rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem.req      <= 1'b0;
            dmem.we       <= 1'b0;
            dmem.addr     <= '0;
            dmem.wdata    <= '0;
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_load      <= 1'b0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            pc_src        <= 1'b0;
            pc_target     <= '0;
            mem_err       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;
            mem_err  <= 1'b0;

            if (accept) begin
                pc_src    <= ex_branch && ex_zero;
                pc_target <= ex_branch_target;
            end

            if (launch) begin
                dmem.req      <= 1'b1;
                dmem.we       <= ex_mem_write;
                dmem.addr     <= ex_result[ADDR_W-1:0];
                dmem.wdata    <= ex_store_data;
                lat_rd        <= ex_rd;
                lat_reg_write <= ex_reg_write;
                lat_load      <= ex_mem_read;
            end

            if (alu_op) begin
                wb_valid     <= 1'b1;
                wb_data      <= ex_result;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write;
            end

            if (bad_op) begin
                wb_valid     <= 1'b1;
                mem_err      <= 1'b1;
                wb_reg_write <= 1'b0;
                wb_rd        <= ex_rd;
            end

            // Stores complete without touching the register file or wb_data
            if (done) begin
                dmem.req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= lat_rd;
                wb_reg_write <= lat_load && lat_reg_write;
                if (lat_load) wb_data <= dmem.rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage.  Directed steps from the test plan are
// followed by randomized instructions.  The reference model works per
// instruction: it classifies each one (ALU, memory, error) from its fields and
// predicts the request, the stall pattern and the writeback bundle.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        ex_branch;
    logic        ex_zero;
    logic [31:0] ex_branch_target;
    logic        stall_flag;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_err;

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_result        (ex_result),
        .ex_store_data    (ex_store_data),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_reg_write     (ex_reg_write),
        .ex_rd            (ex_rd),
        .ex_branch        (ex_branch),
        .ex_zero          (ex_zero),
        .ex_branch_target (ex_branch_target),
        .stall_flag       (stall_flag),
        .dmem             (dmem_bus),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .pc_src           (pc_src),
        .pc_target        (pc_target),
        .mem_err          (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Held-value part of the reference model
    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;
    logic [31:0] exp_pc_target;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Random execute-bundle noise presented while the stage is busy
    task automatic drive_junk();
        ex_valid         = 1'b1;
        ex_result        = $urandom;
        ex_store_data    = $urandom;
        ex_mem_read      = 1'($urandom_range(0, 1));
        ex_mem_write     = 1'($urandom_range(0, 1));
        ex_reg_write     = 1'b1;
        ex_rd            = 5'($urandom);
        ex_branch        = 1'b1;
        ex_zero          = 1'b1;
        ex_branch_target = $urandom;
    endtask

    // One quiet cycle: every pulse low, no request, data outputs held
    task automatic idle_cycle();
        ex_valid = 1'b0;
        @(negedge clk);
        #1;
        check_output("idle_wb_valid", wb_valid, 0);
        check_output("idle_pc_src", pc_src, 0);
        check_output("idle_mem_err", mem_err, 0);
        check_output("idle_req", dmem_bus.req, 0);
        check_output("idle_stall", stall_flag, 0);
        check_output("idle_wb_data", wb_data, exp_wb_data);
    endtask

    // Presents one instruction at the current negedge, services the memory
    // with an ack after 'delay' extra request cycles, and checks everything
    // up to the writeback cycle.  Returns at the writeback negedge so the next
    // call issues back-to-back.
    task automatic apply_stimulus(input logic rd_op, input logic wr_op, input logic reg_wr,
                                  input logic br, input logic zero, input logic [4:0] rd,
                                  input logic [31:0] result, input logic [31:0] sdata,
                                  input logic [31:0] target, input int delay,
                                  input logic [31:0] rdata);
        bit is_err = (rd_op && wr_op) || ((rd_op || wr_op) && (result % 4 != 0));
        bit is_mem = (rd_op || wr_op) && !is_err;

        ex_valid         = 1'b1;
        ex_result        = result;
        ex_store_data    = sdata;
        ex_mem_read      = rd_op;
        ex_mem_write     = wr_op;
        ex_reg_write     = reg_wr;
        ex_rd            = rd;
        ex_branch        = br;
        ex_zero          = zero;
        ex_branch_target = target;
        #1;
        check_output("launch_stall", stall_flag, is_mem);

        @(negedge clk);
        exp_pc_target = target;
        check_output("pc_src", pc_src, br && zero);
        check_output("pc_target", pc_target, exp_pc_target);

        if (is_mem) begin
            check_output("req_rise", dmem_bus.req, 1);
            check_output("req_we", dmem_bus.we, wr_op);
            check_output("req_addr", dmem_bus.addr, result);
            check_output("req_wdata", dmem_bus.wdata, sdata);
            check_output("req_wb_valid", wb_valid, 0);
            check_output("req_mem_err", mem_err, 0);
            for (int i = 0; i <= delay; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    check_output("hold_req", dmem_bus.req, 1);
                    check_output("hold_we", dmem_bus.we, wr_op);
                    check_output("hold_addr", dmem_bus.addr, result);
                    check_output("hold_wdata", dmem_bus.wdata, sdata);
                    check_output("wait_pc_src", pc_src, 0);
                    check_output("wait_wb_valid", wb_valid, 0);
                end
                drive_junk();
                if (i == delay) begin
                    dmem_bus.ack   = 1'b1;
                    dmem_bus.rdata = rdata;
                end
                #1;
                check_output("wait_stall", stall_flag, i != delay);
            end
            @(negedge clk);
            dmem_bus.ack   = 1'b0;
            dmem_bus.rdata = $urandom;
            if (rd_op) exp_wb_data = rdata;
            exp_wb_rd = rd;
            check_output("mem_wb_valid", wb_valid, 1);
            check_output("mem_wb_reg_write", wb_reg_write, rd_op && reg_wr);
            check_output("mem_wb_rd", wb_rd, exp_wb_rd);
            check_output("mem_wb_data", wb_data, exp_wb_data);
            check_output("mem_req_fall", dmem_bus.req, 0);
            check_output("mem_pc_src", pc_src, 0);
            check_output("mem_mem_err", mem_err, 0);
        end else if (is_err) begin
            check_output("err_wb_valid", wb_valid, 1);
            check_output("err_mem_err", mem_err, 1);
            check_output("err_wb_reg_write", wb_reg_write, 0);
            check_output("err_no_req", dmem_bus.req, 0);
            check_output("err_wb_data", wb_data, exp_wb_data);
            exp_wb_rd = rd;
        end else begin
            exp_wb_data = result;
            exp_wb_rd   = rd;
            check_output("alu_wb_valid", wb_valid, 1);
            check_output("alu_wb_data", wb_data, exp_wb_data);
            check_output("alu_wb_rd", wb_rd, exp_wb_rd);
            check_output("alu_wb_reg_write", wb_reg_write, reg_wr);
            check_output("alu_mem_err", mem_err, 0);
            check_output("alu_no_req", dmem_bus.req, 0);
        end
        ex_valid = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        ex_valid         = 1'b0;
        ex_result        = '0;
        ex_store_data    = '0;
        ex_mem_read      = 1'b0;
        ex_mem_write     = 1'b0;
        ex_reg_write     = 1'b0;
        ex_rd            = '0;
        ex_branch        = 1'b0;
        ex_zero          = 1'b0;
        ex_branch_target = '0;
        dmem_bus.ack     = 1'b0;
        dmem_bus.rdata   = '0;
        exp_wb_data      = '0;
        exp_wb_rd        = '0;
        exp_pc_target    = '0;

        // Reset values
        #1;
        check_output("rst_wb_valid", wb_valid, 0);
        check_output("rst_wb_data", wb_data, 0);
        check_output("rst_wb_rd", wb_rd, 0);
        check_output("rst_req", dmem_bus.req, 0);
        check_output("rst_we", dmem_bus.we, 0);
        check_output("rst_pc_target", pc_target, 0);
        check_output("rst_stall", stall_flag, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ALU op
        apply_stimulus(0, 0, 1, 0, 0, 5'd5, 32'h2A, 32'h0, 32'h0, 0, 32'h0);
        idle_cycle();
        // Load with ack delay, then store acked in the first request cycle
        apply_stimulus(1, 0, 1, 0, 0, 5'd7, 32'h100, 32'h1234, 32'h0, 3, 32'hDEADBEEF);
        apply_stimulus(0, 1, 1, 0, 0, 5'd9, 32'h10, 32'h55, 32'h0, 0, 32'hFFFF0000);
        idle_cycle();
        // Misaligned load, and read+write both set
        apply_stimulus(1, 0, 1, 0, 0, 5'd3, 32'h102, 32'h0, 32'h0, 0, 32'h0);
        idle_cycle();
        apply_stimulus(1, 1, 1, 0, 0, 5'd4, 32'h200, 32'h0, 32'h0, 0, 32'h0);
        idle_cycle();
        // Branch taken, then not taken
        apply_stimulus(0, 0, 0, 1, 1, 5'd0, 32'h0, 32'h0, 32'h40, 0, 32'h0);
        idle_cycle();
        apply_stimulus(0, 0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h80, 0, 32'h0);
        idle_cycle();
        // Back-to-back loads
        apply_stimulus(1, 0, 1, 0, 0, 5'd10, 32'h300, 32'h0, 32'h0, 1, 32'hA5A5A5A5);
        apply_stimulus(1, 0, 1, 0, 0, 5'd11, 32'h304, 32'h0, 32'h0, 0, 32'h5A5A5A5A);
        idle_cycle();

        // Reset while in WAIT
        ex_valid      = 1'b1;
        ex_result     = 32'h400;
        ex_mem_read   = 1'b1;
        ex_mem_write  = 1'b0;
        ex_branch     = 1'b0;
        @(negedge clk);
        check_output("pre_rst_req", dmem_bus.req, 1);
        ex_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_output("wait_rst_req", dmem_bus.req, 0);
        check_output("wait_rst_stall", stall_flag, 0);
        check_output("wait_rst_wb_valid", wb_valid, 0);
        exp_wb_data   = '0;
        exp_wb_rd     = '0;
        exp_pc_target = '0;
        @(negedge clk);
        reset = 1'b0;
        idle_cycle();
        apply_stimulus(0, 0, 1, 0, 0, 5'd12, 32'hCAFE, 32'h0, 32'h0, 0, 32'h0);
        // Stray ack in IDLE
        ex_valid     = 1'b0;
        dmem_bus.ack = 1'b1;
        #1;
        check_output("stray_stall", stall_flag, 0);
        @(negedge clk);
        dmem_bus.ack = 1'b0;
        check_output("stray_wb_valid", wb_valid, 0);
        check_output("stray_req", dmem_bus.req, 0);
        check_output("stray_mem_err", mem_err, 0);
        idle_cycle();

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            int          op    = $urandom_range(0, 7);
            logic        rd_op = (op == 1) || (op == 2) || (op == 7);
            logic        wr_op = (op == 3) || (op == 4) || (op == 7);
            logic [31:0] addr  = $urandom;
            if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            apply_stimulus(rd_op, wr_op, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           5'($urandom), addr, $urandom, $urandom,
                           $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
